divide_32: RTL and testbench

Unsigned sequential restoring divider: the inverse of the shift-add multiplier in the execution unit. Accepts an N-bit dividend and divisor, produces an N-bit quotient and remainder in a fixed N+2 enabled cycles, one quotient bit per cycle. It sits beside the multiplier in the execution unit and uses the same enable/ready handshake so the same control logic can drive either unit.

---
 rtl/divide_32.sv | 138 +++++++++++++
 tb/tb_divide_32.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/divide_32.sv
// divide_32: unsigned sequential restoring divider, one quotient bit per
// enabled cycle. Shares the enable/ready handshake of the shift-add multiplier.
module divide_32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  // Step counter runs 0 (capture), 1..N (iterate), N+1 (done).
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] DONE_STEP = CW'(N + 1);

  typedef enum logic [1:0] {
    PH_CAPTURE,
    PH_ITERATE,
    PH_DONE
  } phase_t;

  phase_t phase;

  logic [CW-1:0] count, count_nxt;
  logic [N:0]    rem_reg, rem_nxt;
  logic [N-1:0]  quot_reg, quot_nxt;
  logic [N-1:0]  divisor_reg, divisor_nxt;
  logic          dbz_reg, dbz_nxt;

  logic          ready_nxt;
  logic [N-1:0]  quotient_nxt;
  logic [N-1:0]  remainder_nxt;
  logic          div_by_zero_nxt;

  logic [N+1:0]  wide_shift;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          take;

  // Decode the step counter into the three operating phases.
  always_comb begin
    phase = PH_ITERATE;
    if (count == '0) begin
      phase = PH_CAPTURE;
    end else if (count == DONE_STEP) begin
      phase = PH_DONE;
    end
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The guard bit rem_reg[N] is kept
  // in the comparison so the whole register takes part in the decision.
  always_comb begin
    wide_shift = {rem_reg, quot_reg[N-1]};
    shifted    = wide_shift[N:0];
    trial      = shifted - {1'b0, divisor_reg};
    take       = (wide_shift >= {2'b00, divisor_reg});
  end

  // Next-state logic for counter, datapath and result registers; everything
  // holds by default so a low enable freezes the whole block.
  always_comb begin
    count_nxt       = count;
    rem_nxt         = rem_reg;
    quot_nxt        = quot_reg;
    divisor_nxt     = divisor_reg;
    dbz_nxt         = dbz_reg;
    ready_nxt       = ready;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;

    if (enable) begin
      case (phase)
        PH_CAPTURE: begin
          quot_nxt    = dividend;
          divisor_nxt = divisor;
          rem_nxt     = '0;
          dbz_nxt     = (divisor == '0);
          ready_nxt   = 1'b0;
          count_nxt   = CW'(1);
        end
        PH_ITERATE: begin
          if (take) begin
            rem_nxt  = trial;
            quot_nxt = {quot_reg[N-2:0], 1'b1};
          end else begin
            rem_nxt  = shifted;
            quot_nxt = {quot_reg[N-2:0], 1'b0};
          end
          count_nxt = count + CW'(1);
        end
        PH_DONE: begin
          quotient_nxt    = quot_reg;
          remainder_nxt   = rem_reg[N-1:0];
          div_by_zero_nxt = dbz_reg;
          ready_nxt       = 1'b1;
          count_nxt       = '0;
        end
        default: begin
          count_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset that
  // takes priority over enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count       <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      dbz_reg     <= 1'b0;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      count       <= count_nxt;
      rem_reg     <= rem_nxt;
      quot_reg    <= quot_nxt;
      divisor_reg <= divisor_nxt;
      dbz_reg     <= dbz_nxt;
      ready       <= ready_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule

// File: tb/tb_divide_32.sv
// tb_divide_32: scoreboard bench for divide_32 with a plain-arithmetic
// reference model, directed cases, stalls, mid-operation reset and random pairs.
module tb_divide_32;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } result_t;

  result_t exp_q[$];
  result_t model_out;
  logic    model_ready;
  logic    prev_ready = 1'b0;
  int      tests = 0;
  int      fails = 0;

  divide_32 #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference result: ordinary division, with the all-ones/dividend
  // answer a restoring divider produces for a zero divisor.
  function automatic result_t refDivide(input logic [N-1:0] a, input logic [N-1:0] b);
    result_t res;
    if (b == '0) begin
      res.q   = '1;
      res.r   = a;
      res.dbz = 1'b1;
    end else begin
      res.q   = a / b;
      res.r   = a % b;
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against what the block should currently be showing.
  task automatic checkHeld(input string tag);
    checkOutput({tag, " ready"},       64'(ready),       64'(model_ready));
    checkOutput({tag, " quotient"},    64'(quotient),    64'(model_out.q));
    checkOutput({tag, " remainder"},   64'(remainder),   64'(model_out.r));
    checkOutput({tag, " div_by_zero"}, 64'(div_by_zero), 64'(model_out.dbz));
  endtask

  // One full division: optional idle gap, capture, N+1 further enabled
  // edges with an optional stall inserted before step stall_at.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input int pre_gap, input int stall_at, input int stall_len);
    result_t res;
    res = refDivide(a, b);
    enable = 1'b0;
    repeat (pre_gap) begin
      @(posedge clk); #1;
      checkHeld("gap");
    end
    dividend = a;
    divisor  = b;
    enable   = 1'b1;
    exp_q.push_back(res);
    @(posedge clk); #1;
    model_ready = 1'b0;
    checkHeld("capture");
    dividend = $urandom;
    divisor  = $urandom;
    for (int step = 1; step <= N + 1; step++) begin
      if (step == stall_at && stall_len > 0) begin
        enable = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          checkHeld("stall");
        end
        enable = 1'b1;
      end
      @(posedge clk); #1;
      if (step == N) checkOutput("early ready", 64'(ready), 64'(0));
    end
    model_ready = 1'b1;
    model_out   = res;
    checkOutput("latency ready", 64'(ready), 64'(1));
  endtask

  // Start a division, then pull reset low (with enable low) after the given
  // number of iteration edges; everything must read zero afterwards.
  task automatic resetMid(input logic [N-1:0] a, input logic [N-1:0] b, input int at_step);
    dividend = a;
    divisor  = b;
    enable   = 1'b1;
    exp_q.push_back(refDivide(a, b));
    @(posedge clk); #1;
    model_ready = 1'b0;
    checkHeld("capture");
    repeat (at_step) @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    model_ready = 1'b0;
    model_out   = '0;
    void'(exp_q.pop_back());
    checkHeld("mid reset");
    reset = 1'b1;
  endtask

  // Monitor: each rising ready retires the oldest expected result.
  always @(negedge clk) begin
    if (ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected ready", 64'(ready), 64'(0));
      end else begin
        result_t e;
        e = exp_q.pop_front();
        checkOutput("sb quotient",    64'(quotient),    64'(e.q));
        checkOutput("sb remainder",   64'(remainder),   64'(e.r));
        checkOutput("sb div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
    prev_ready <= ready;
  end

  // Directed sequence followed by randomized pairs.
  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    int kind;
    int gap;
    int st_at;
    int st_len;

    reset       = 1'b0;
    enable      = 1'b0;
    dividend    = '0;
    divisor     = '0;
    model_ready = 1'b0;
    model_out   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkHeld("reset state");
    reset = 1'b1;

    applyStimulus(32'd100, 32'd7, 0, 0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    applyStimulus(32'd3, 32'd10, 0, 0, 0);
    applyStimulus(32'd5, 32'd0, 0, 0, 0);
    applyStimulus(32'd9, 32'd3, 0, 0, 0);
    applyStimulus(32'hDEAD_BEEF, 32'h1234, 0, 12, 5);
    applyStimulus(32'd77, 32'd77, 3, 0, 0);
    resetMid(32'd1234, 32'd5, 10);
    applyStimulus(32'd1000, 32'd33, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 5);
      a    = $urandom;
      case (kind)
        0: b = 32'd1;
        1: b = a;
        2: begin
          a = 32'($urandom_range(0, 1000));
          b = a + 32'd1 + 32'($urandom_range(0, 100000));
        end
        3: b = '0;
        4: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      gap    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      st_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N + 1) : 0;
      st_len = $urandom_range(1, 4);
      applyStimulus(a, b, gap, st_at, st_len);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
